instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/mips_pkg.sv | 15 +
 rtl/next_pc_logic.sv | 39 +++
 rtl/instr_fetch.sv | 100 ++++++++++
 tb/tb_instr_fetch.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch front end: opcodes, the fetch
// FSM encoding and the default instruction-memory address width.
package mips_pkg;

    localparam int IMEM_AW_DEF = 5;

    localparam logic [5:0] OP_J = 6'b000010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection for a running fetch unit:
// jump beats taken branch, which beats sequential PC+1, all modulo 2^IMEM_AW.
module next_pc_logic
    import mips_pkg::*;
#(
    parameter int IMEM_AW = IMEM_AW_DEF
) (
    input  logic [IMEM_AW-1:0] pc,
    input  logic               jump,
    input  logic [25:0]        jump_target,
    input  logic               branch_taken,
    input  logic [15:0]        branch_offset,
    output logic [IMEM_AW-1:0] next_pc
);

    logic [31:0] pc_ext;
    logic [31:0] off_ext;
    logic [31:0] br_sum;
    logic [IMEM_AW-1:0] seq_pc;
    logic unused_hi_bits;

    // Branch arithmetic is done at full width, then truncated to wrap the PC.
    assign pc_ext  = {{(32-IMEM_AW){1'b0}}, pc};
    assign off_ext = {{16{branch_offset[15]}}, branch_offset};
    assign br_sum  = pc_ext + 32'd1 + off_ext;
    assign seq_pc  = pc + {{(IMEM_AW-1){1'b0}}, 1'b1};

    assign unused_hi_bits = ^{br_sum[31:IMEM_AW], jump_target[25:IMEM_AW]};

    always_comb begin
        next_pc = seq_pc;
        if (jump) begin
            next_pc = jump_target[IMEM_AW-1:0];
        end else if (branch_taken) begin
            next_pc = br_sum[IMEM_AW-1:0];
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, IDLE/RUN/HALT control, redirect
// handling and a saturating retired-instruction counter.
module instr_fetch
    import mips_pkg::*;
#(
    parameter int IMEM_AW = IMEM_AW_DEF,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [15:0]        branch_offset,
    input  logic               jump,
    input  logic [25:0]        jump_target,
    input  logic [31:0]        imem_spo,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        instr,
    output logic               instr_valid,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    fetch_state_t       state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [IMEM_AW-1:0] redirect_pc;
    logic               self_jump;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    next_pc_logic #(
        .IMEM_AW(IMEM_AW)
    ) u_next_pc (
        .pc           (pc_q),
        .jump         (jump),
        .jump_target  (jump_target),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .next_pc      (redirect_pc)
    );

    // A jump to its own address is the program's way of saying "done".
    assign self_jump = (imem_spo[31:26] == OP_J) && (imem_spo[IMEM_AW-1:0] == pc_q);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    if (self_jump) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d      = redirect_pc;
                        retired_d = sat_inc(retired_q);
                    end
                end
            end
            ST_HALT: begin
                if (start) begin
                    state_d   = ST_RUN;
                    pc_d      = '0;
                    retired_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == ST_RUN);
    assign halted      = (state_q == ST_HALT);
    assign instr       = instr_valid ? imem_spo : 32'h0;
    assign retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed scenarios followed by random
// traffic, each cycle's expected outputs produced by a behavioural model.
module tb_instr_fetch;

    localparam int AW   = 5;
    localparam int CW   = 16;
    localparam int NWRD = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, stall, branch_taken, jump;
    logic [15:0]   branch_offset;
    logic [25:0]   jump_target;
    logic [31:0]   imem_spo;
    logic [AW-1:0] imem_addr;
    logic [31:0]   instr;
    logic          instr_valid, halted;
    logic [CW-1:0] retired;

    logic [31:0] imem [NWRD];
    assign imem_spo = imem[imem_addr];

    instr_fetch #(.IMEM_AW(AW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_target  (jump_target),
        .imem_spo     (imem_spo),
        .imem_addr    (imem_addr),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .halted       (halted),
        .retired      (retired)
    );

    typedef struct {
        int          addr;
        logic [31:0] instr;
        logic        valid;
        logic        halted;
        int          ret;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Model state: mode 0 = idle, 1 = running, 2 = halted.
    int    m_mode = 0;
    int    m_pc   = 0;
    int    m_ret  = 0;
    string cur_tag = "init";

    task automatic chk(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, req, req, $time);
        end
    endtask

    // Monitor: compare whatever the DUT shows on each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.tag, ".imem_addr"},   longint'(imem_addr),   longint'(e.addr));
                chk({e.tag, ".instr"},       longint'(instr),       longint'(e.instr));
                chk({e.tag, ".instr_valid"}, longint'(instr_valid), longint'(e.valid));
                chk({e.tag, ".halted"},      longint'(halted),      longint'(e.halted));
                chk({e.tag, ".retired"},     longint'(retired),     longint'(e.ret));
            end
        end
    end

    function automatic logic [31:0] plain_word();
        logic [31:0] w;
        w = $urandom;
        w[31:26] = 6'b001000;
        return w;
    endfunction

    // Advance one clock with the currently driven inputs.
    task automatic step();
        int nm, npc, nr, off;
        logic [31:0] w;
        exp_t e;
        nm = m_mode; npc = m_pc; nr = m_ret;
        if (rst) begin
            nm = 0; npc = 0; nr = 0;
        end else if (m_mode == 0) begin
            if (start) nm = 1;
        end else if (m_mode == 2) begin
            if (start) begin nm = 1; npc = 0; nr = 0; end
        end else if (!stall) begin
            w = imem[m_pc];
            if (w[31:26] == 6'b000010 && int'(w[AW-1:0]) == m_pc) begin
                nm = 2;
            end else begin
                if (jump) begin
                    npc = int'(jump_target) % NWRD;
                end else if (branch_taken) begin
                    off = int'($signed(branch_offset));
                    npc = ((m_pc + 1 + off) % NWRD + NWRD) % NWRD;
                end else begin
                    npc = (m_pc + 1) % NWRD;
                end
                nr = (m_ret < 65535) ? m_ret + 1 : m_ret;
            end
        end
        m_mode = nm; m_pc = npc; m_ret = nr;
        @(posedge clk);
        #1;
        e.addr   = m_pc;
        e.valid  = (m_mode == 1);
        e.halted = (m_mode == 2);
        e.instr  = (m_mode == 1) ? imem[m_pc] : 32'h0;
        e.ret    = m_ret;
        e.tag    = cur_tag;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic st,
                         input logic j, input int jt, input logic b, input logic [15:0] off);
        rst = r; start = s; stall = st; jump = j;
        jump_target = 26'(jt); branch_taken = b; branch_offset = off;
        step();
    endtask

    task automatic go_to(input int pc);
        drive(0, 0, 0, 1, pc, 0, 16'h0);
    endtask

    task automatic idle_step();
        drive(0, 0, 0, 0, 0, 0, 16'h0);
    endtask

    initial begin
        rst = 0; start = 0; stall = 0; jump = 0; branch_taken = 0;
        jump_target = '0; branch_offset = '0;
        for (int i = 0; i < NWRD; i++) imem[i] = plain_word();
        @(negedge clk);
        #1;

        cur_tag = "reset";
        drive(1, 0, 0, 0, 0, 0, 16'h0);
        drive(1, 1, 0, 0, 0, 0, 16'h0);
        idle_step();

        cur_tag = "seq";
        drive(0, 1, 0, 0, 0, 0, 16'h0);
        idle_step(); idle_step(); idle_step();
        drive(0, 1, 0, 0, 0, 0, 16'h0);

        cur_tag = "branch";
        go_to(10);
        drive(0, 0, 0, 0, 0, 1, 16'hfff9);
        go_to(10);
        drive(0, 0, 0, 1, 7, 1, 16'hfff9);

        cur_tag = "wrap";
        go_to(31);
        idle_step();
        go_to(1);
        drive(0, 0, 0, 0, 0, 1, 16'hfffd);

        cur_tag = "stall";
        go_to(5);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 20, 1, 16'h0004);
        drive(0, 0, 0, 1, 20, 0, 16'h0);

        cur_tag = "halt";
        imem[11] = {6'b000010, 26'd11};
        go_to(11);
        idle_step();
        drive(0, 0, 0, 1, 3, 1, 16'h0002);
        drive(0, 0, 1, 0, 0, 0, 16'h0);
        drive(0, 1, 0, 0, 0, 0, 16'h0);
        imem[11] = plain_word();
        idle_step();

        cur_tag = "rst_run";
        go_to(9);
        drive(1, 1, 0, 1, 4, 0, 16'h0);
        idle_step();

        cur_tag = "random";
        for (int i = 0; i < NWRD; i++) begin
            case ($urandom_range(7))
                0, 1:    imem[i] = {6'b000010, 26'(i)};
                2:       imem[i] = {6'b000010, 26'($urandom)};
                default: imem[i] = plain_word();
            endcase
        end
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(63) == 0),
                  ($urandom_range(5) == 0),
                  ($urandom_range(3) == 0),
                  ($urandom_range(5) == 0),
                  int'($urandom_range(32'h3ff_ffff)),
                  ($urandom_range(3) == 0),
                  ($urandom_range(1) == 0) ? 16'($urandom) : 16'($signed(int'($urandom_range(8)) - 4)));
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", longint'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
